// File: rtl/drw_vramctrl_p.sv
// Line-based VRAM DMA controller: up to two AXI read streams (SRC, DST) feed FIFOs,
// and one AXI write stream drains the result FIFO. Bursts are split at 4 KB and BURST_MAX.
module drw_vramctrl_p #(
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 32,
  parameter int FIFO_CW   = 12
) (
  input  logic                CLK,
  input  logic                ARST,
  output logic [31:0]         M_AXI_ARADDR,
  output logic [7:0]          M_AXI_ARLEN,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  output logic [31:0]         M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  input  logic                LINE_START,
  output logic                LINE_BUSY,
  output logic                LINE_ERR,
  input  logic [31:0]         LINE_ADDR_DST,
  input  logic [31:0]         LINE_ADDR_SRC,
  input  logic [10:0]         LINE_LEN,
  input  logic                CMD_MODE,
  input  logic                PARAM_BLEND,
  input  logic [FIFO_CW-1:0]  SRC_FIFO_FREE,
  input  logic [FIFO_CW-1:0]  DST_FIFO_FREE,
  output logic                SRC_FIFO_WR,
  output logic                DST_FIFO_WR,
  output logic [DATA_W-1:0]   SRC_FIFO_WDATA,
  output logic [DATA_W-1:0]   DST_FIFO_WDATA,
  input  logic [FIFO_CW-1:0]  WRT_FIFO_COUNT,
  input  logic [DATA_W-1:0]   WRT_FIFO_RDATA,
  output logic                WRT_FIFO_RD
);
  localparam int BSH = $clog2(DATA_W/8);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;

  rstate_e     rstate_q, rstate_d;
  wstate_e     wstate_q, wstate_d;
  logic        busy_q, busy_d, err_q, err_d;
  logic        rsel_q, rsel_d, prio_q, prio_d;
  logic [31:0] src_addr_q, src_addr_d, dst_addr_q, dst_addr_d, wr_addr_q, wr_addr_d;
  logic [10:0] src_rem_q, src_rem_d, dst_rem_q, dst_rem_d, wr_rem_q, wr_rem_d;
  logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [7:0]  arlen_q, arlen_d, awlen_q, awlen_d, wbeat_q, wbeat_d;
  logic [8:0]  src_beats, dst_beats, wr_beats, sel_beats, rnb, wnb;
  logic        src_ok, dst_ok, wr_ok, sel;

  // Beats allowed from this address: limited by BURST_MAX, stream remainder and the 4 KB page.
  function automatic logic [8:0] calc_beats(input logic [11:0] lo, input logic [10:0] rem);
    logic [12:0] b;
    b = (13'd4096 - {1'b0, lo}) >> BSH;
    if (b > 13'(BURST_MAX)) b = 13'(BURST_MAX);
    if (b > {2'b0, rem})    b = {2'b0, rem};
    return b[8:0];
  endfunction

  assign src_beats = calc_beats(src_addr_q[11:0], src_rem_q);
  assign dst_beats = calc_beats(dst_addr_q[11:0], dst_rem_q);
  assign wr_beats  = calc_beats(wr_addr_q[11:0], wr_rem_q);
  assign src_ok    = (src_rem_q != 11'd0) && (32'(SRC_FIFO_FREE) >= 32'(src_beats));
  assign dst_ok    = (dst_rem_q != 11'd0) && (32'(DST_FIFO_FREE) >= 32'(dst_beats));
  assign wr_ok     = (wr_rem_q != 11'd0) && (32'(WRT_FIFO_COUNT) >= 32'(wr_beats));
  assign sel       = (src_ok && dst_ok) ? prio_q : dst_ok;
  assign sel_beats = sel ? dst_beats : src_beats;
  assign rnb       = {1'b0, arlen_q} + 9'd1;
  assign wnb       = {1'b0, awlen_q} + 9'd1;

  always_comb begin
    rstate_d = rstate_q;  wstate_d = wstate_q;
    busy_d = busy_q;      err_d = err_q;
    rsel_d = rsel_q;      prio_d = prio_q;
    src_addr_d = src_addr_q; dst_addr_d = dst_addr_q; wr_addr_d = wr_addr_q;
    src_rem_d = src_rem_q;   dst_rem_d = dst_rem_q;   wr_rem_d = wr_rem_q;
    araddr_d = araddr_q; arlen_d = arlen_q;
    awaddr_d = awaddr_q; awlen_d = awlen_q; wbeat_d = wbeat_q;

    // Inactive read streams start with zero remaining, so they never become eligible.
    if (LINE_START && !busy_q) begin
      busy_d     = 1'b1;
      err_d      = 1'b0;
      src_addr_d = LINE_ADDR_SRC;
      dst_addr_d = LINE_ADDR_DST;
      wr_addr_d  = LINE_ADDR_DST;
      src_rem_d  = CMD_MODE ? LINE_LEN : 11'd0;
      dst_rem_d  = PARAM_BLEND ? LINE_LEN : 11'd0;
      wr_rem_d   = LINE_LEN;
    end

    case (rstate_q)
      R_IDLE: if (src_ok || dst_ok) begin
        rsel_d   = sel;
        araddr_d = sel ? dst_addr_q : src_addr_q;
        arlen_d  = 8'(sel_beats - 9'd1);
        rstate_d = R_ADDR;
      end
      R_ADDR: if (M_AXI_ARREADY) rstate_d = R_DATA;
      R_DATA: if (M_AXI_RVALID) begin
        if (M_AXI_RRESP != 2'b00) err_d = 1'b1;
        if (M_AXI_RLAST) begin
          if (rsel_q) begin
            dst_addr_d = dst_addr_q + (32'(rnb) << BSH);
            dst_rem_d  = dst_rem_q - 11'(rnb);
          end else begin
            src_addr_d = src_addr_q + (32'(rnb) << BSH);
            src_rem_d  = src_rem_q - 11'(rnb);
          end
          prio_d   = ~prio_q;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    case (wstate_q)
      W_IDLE: if (wr_ok) begin
        awaddr_d = wr_addr_q;
        awlen_d  = 8'(wr_beats - 9'd1);
        wstate_d = W_ADDR;
      end
      W_ADDR: if (M_AXI_AWREADY) begin
        wbeat_d  = 8'd0;
        wstate_d = W_DATA;
      end
      W_DATA: if (M_AXI_WREADY) begin
        wbeat_d = wbeat_q + 8'd1;
        if (wbeat_q == awlen_q) wstate_d = W_RESP;
      end
      W_RESP: if (M_AXI_BVALID) begin
        if (M_AXI_BRESP != 2'b00) err_d = 1'b1;
        wr_addr_d = wr_addr_q + (32'(wnb) << BSH);
        wr_rem_d  = wr_rem_q - 11'(wnb);
        wstate_d  = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase

    // Drop busy on the same edge that retires the last burst.
    if (busy_q && src_rem_d == 11'd0 && dst_rem_d == 11'd0 && wr_rem_d == 11'd0 &&
        rstate_d == R_IDLE && wstate_d == W_IDLE)
      busy_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (ARST) begin
      rstate_q <= R_IDLE;  wstate_q <= W_IDLE;
      busy_q <= 1'b0;      err_q <= 1'b0;
      rsel_q <= 1'b0;      prio_q <= 1'b0;
      src_addr_q <= '0; dst_addr_q <= '0; wr_addr_q <= '0;
      src_rem_q <= '0;  dst_rem_q <= '0;  wr_rem_q <= '0;
      araddr_q <= '0; arlen_q <= '0; awaddr_q <= '0; awlen_q <= '0; wbeat_q <= '0;
    end else begin
      rstate_q <= rstate_d;  wstate_q <= wstate_d;
      busy_q <= busy_d;      err_q <= err_d;
      rsel_q <= rsel_d;      prio_q <= prio_d;
      src_addr_q <= src_addr_d; dst_addr_q <= dst_addr_d; wr_addr_q <= wr_addr_d;
      src_rem_q <= src_rem_d;   dst_rem_q <= dst_rem_d;   wr_rem_q <= wr_rem_d;
      araddr_q <= araddr_d; arlen_q <= arlen_d; awaddr_q <= awaddr_d; awlen_q <= awlen_d;
      wbeat_q <= wbeat_d;
    end
  end

  assign M_AXI_ARVALID  = (rstate_q == R_ADDR);
  assign M_AXI_ARADDR   = araddr_q;
  assign M_AXI_ARLEN    = arlen_q;
  assign M_AXI_RREADY   = (rstate_q == R_DATA);
  assign SRC_FIFO_WR    = M_AXI_RREADY && M_AXI_RVALID && !rsel_q;
  assign DST_FIFO_WR    = M_AXI_RREADY && M_AXI_RVALID && rsel_q;
  assign SRC_FIFO_WDATA = (M_AXI_RREADY && !rsel_q) ? M_AXI_RDATA : '0;
  assign DST_FIFO_WDATA = (M_AXI_RREADY && rsel_q) ? M_AXI_RDATA : '0;
  assign M_AXI_AWVALID  = (wstate_q == W_ADDR);
  assign M_AXI_AWADDR   = awaddr_q;
  assign M_AXI_AWLEN    = awlen_q;
  assign M_AXI_WVALID   = (wstate_q == W_DATA);
  assign M_AXI_WDATA    = M_AXI_WVALID ? WRT_FIFO_RDATA : '0;
  assign M_AXI_WSTRB    = M_AXI_WVALID ? '1 : '0;
  assign M_AXI_WLAST    = M_AXI_WVALID && (wbeat_q == awlen_q);
  assign WRT_FIFO_RD    = M_AXI_WVALID && M_AXI_WREADY;
  assign M_AXI_BREADY   = (wstate_q == W_RESP);
  assign LINE_BUSY      = busy_q;
  assign LINE_ERR       = err_q;
endmodule
